// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared BCD constants and serial adder FSM encoding
//
// Purpose : constants for one BCD digit and the state encoding of the
//           digit-serial adder. Imported by bcdadd4 and bcdaddn_serial.
// Ports   : none (package)
package bcd_pkg;

  localparam int BCD_W   = 4;  // bits per BCD digit
  localparam int BCD_MAX = 9;  // largest legal digit value
  localparam int BCD_ADJ = 6;  // decimal correction added when a digit sum exceeds 9

  typedef enum logic {
    IDLE = 1'b0,
    ADD  = 1'b1
  } state_t;

endpackage

// File: rtl/bcdadd4.sv
// rtl/bcdadd4.sv - single-digit combinational BCD adder with decimal correction
//
// Purpose : adds two BCD digits and a carry-in, applying the +6 correction
//           whenever the 5-bit binary sum exceeds 9. Digits above 9 are not
//           rejected; the same correction rule is applied to them.
// Ports   : A, B  - digit operands
//           C0    - carry-in
//           S     - corrected sum digit
//           Carry - decimal carry-out
module bcdadd4
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] A,
  input  logic [BCD_W-1:0] B,
  input  logic             C0,
  output logic [BCD_W-1:0] S,
  output logic             Carry
);

  logic [BCD_W:0] t;

  always_comb begin
    t = {1'b0, A} + {1'b0, B} + {{BCD_W{1'b0}}, C0};
    if (int'(t) > BCD_MAX) begin
      // Only the low nibble matters: (t + 6) mod 16.
      S     = t[BCD_W-1:0] + BCD_ADJ[BCD_W-1:0];
      Carry = 1'b1;
    end else begin
      S     = t[BCD_W-1:0];
      Carry = 1'b0;
    end
  end

endmodule

// File: rtl/bcdaddn_serial.sv
// rtl/bcdaddn_serial.sv - NDIG-digit BCD adder processing one digit per clock
//
// Purpose : adds two NDIG-digit BCD operands plus a carry-in using a single
//           time-shared bcdadd4. The operand registers shift right by one
//           digit per ADD cycle, so the digit adder always reads bits [3:0];
//           idx only selects which sum digit is written.
// Ports   : clk   - clock, rising edge
//           rst   - asynchronous active-high reset
//           start - request an addition (ignored while busy)
//           A, B  - BCD operands, digit 0 in bits [3:0]
//           C0    - carry-in to digit 0
//           S     - registered BCD sum
//           Carry - registered carry-out of the top digit
//           busy  - addition in progress
//           done  - one-cycle pulse, S/Carry/err valid
//           err   - some operand digit of the last addition was above 9
module bcdaddn_serial
  import bcd_pkg::*;
#(
  parameter int NDIG = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BCD_W*NDIG-1:0] A,
  input  logic [BCD_W*NDIG-1:0] B,
  input  logic                  C0,
  output logic [BCD_W*NDIG-1:0] S,
  output logic                  Carry,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int            IW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IW-1:0] LAST = IW'(NDIG - 1);

  state_t                  state, state_nx;
  logic [BCD_W*NDIG-1:0]   a_r, b_r;
  logic [IW-1:0]           idx;
  logic                    c_r;
  logic [BCD_W-1:0]        dsum;
  logic                    dcarry;
  logic                    dig_err;
  logic                    last;

  bcdadd4 u_dig (
    .A     (a_r[BCD_W-1:0]),
    .B     (b_r[BCD_W-1:0]),
    .C0    (c_r),
    .S     (dsum),
    .Carry (dcarry)
  );

  assign last    = (idx == LAST);
  assign dig_err = (int'(a_r[BCD_W-1:0]) > BCD_MAX) || (int'(b_r[BCD_W-1:0]) > BCD_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = ADD;
      ADD:     if (last)  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == ADD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r   <= '0;
      b_r   <= '0;
      c_r   <= 1'b0;
      idx   <= '0;
      S     <= '0;
      Carry <= 1'b0;
      err   <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_r   <= A;
            b_r   <= B;
            c_r   <= C0;
            idx   <= '0;
            S     <= '0;
            Carry <= 1'b0;
            err   <= 1'b0;
          end
        end
        ADD: begin
          S[idx*BCD_W +: BCD_W] <= dsum;
          a_r <= a_r >> BCD_W;
          b_r <= b_r >> BCD_W;
          c_r <= dcarry;
          idx <= idx + 1'b1;
          if (dig_err) err <= 1'b1;
          if (last) begin
            Carry <= dcarry;
            done  <= 1'b1;
            idx   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcdaddn_serial.sv
// tb/tb_bcdaddn_serial.sv - scoreboard bench for bcdaddn_serial at NDIG = 1, 4, 8
module tb_bcdaddn_serial;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  start = 3'b000;
  logic [31:0] a_w = '0;
  logic [31:0] b_w = '0;
  logic        c0 = 1'b0;

  logic [3:0]  s1;
  logic [15:0] s4;
  logic [31:0] s8;
  logic [2:0]  carry, busy, done, err;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bcdaddn_serial #(.NDIG(1)) u_d1 (
    .clk(clk), .rst(rst), .start(start[0]), .A(a_w[3:0]), .B(b_w[3:0]), .C0(c0),
    .S(s1), .Carry(carry[0]), .busy(busy[0]), .done(done[0]), .err(err[0]));
  bcdaddn_serial #(.NDIG(4)) u_d4 (
    .clk(clk), .rst(rst), .start(start[1]), .A(a_w[15:0]), .B(b_w[15:0]), .C0(c0),
    .S(s4), .Carry(carry[1]), .busy(busy[1]), .done(done[1]), .err(err[1]));
  bcdaddn_serial #(.NDIG(8)) u_d8 (
    .clk(clk), .rst(rst), .start(start[2]), .A(a_w), .B(b_w), .C0(c0),
    .S(s8), .Carry(carry[2]), .busy(busy[2]), .done(done[2]), .err(err[2]));

  typedef struct {
    int          sel;
    logic [31:0] s;
    logic        c;
    logic        e;
    int          t;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   n_done = 0;
  int   n_push = 0;

  function automatic int ndig(input int sel);
    return (sel == 0) ? 1 : (sel == 1) ? 4 : 8;
  endfunction

  function automatic logic [31:0] mask(input int n);
    logic [31:0] one;
    one = 32'h1;
    return (n >= 8) ? 32'hFFFF_FFFF : ((one << (4 * n)) - 32'h1);
  endfunction

  function automatic logic [31:0] get_s(input int sel);
    case (sel)
      0:       return {28'h0, s1};
      1:       return {16'h0, s4};
      default: return s8;
    endcase
  endfunction

  function automatic longint dec(input logic [31:0] v, input int n);
    longint r;
    r = 0;
    for (int i = n - 1; i >= 0; i--) r = r * 10 + longint'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [31:0] tobcd(input longint v, input int n);
    logic [31:0] r;
    longint      x;
    r = '0;
    x = v;
    for (int i = 0; i < n; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [31:0] rand_bcd(input int n);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  // Decimal reference: operands are truncated to the DUT width first.
  task automatic model(input int sel, input logic [31:0] a, input logic [31:0] b, input logic c,
                       output logic [31:0] es, output logic ec, output logic ee);
    int          n;
    longint      lim, sum;
    logic [31:0] am, bm;
    n   = ndig(sel);
    am  = a & mask(n);
    bm  = b & mask(n);
    lim = 1;
    for (int i = 0; i < n; i++) lim = lim * 10;
    sum = dec(am, n) + dec(bm, n) + longint'(c);
    ec  = (sum >= lim);
    es  = tobcd(sum % lim, n);
    ee  = 1'b0;
    for (int i = 0; i < n; i++)
      if (am[4*i +: 4] > 4'd9 || bm[4*i +: 4] > 4'd9) ee = 1'b1;
  endtask

  // Scoreboard consumer: every done pulse pops one expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      if (done[k] === 1'b1) begin
        n_done++;
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done dut=%0d got done=1 want no pending result", k);
        end else begin
          e = q.pop_front();
          if (e.sel != k) begin
            errors++;
            $display("FAIL done_source got dut=%0d want dut=%0d", k, e.sel);
          end
          checks++;
          if (get_s(k) !== e.s) begin
            errors++;
            $display("FAIL sum dut=%0d got S=%h want %h", k, get_s(k), e.s);
          end
          checks++;
          if (carry[k] !== e.c) begin
            errors++;
            $display("FAIL carry dut=%0d got %b want %b", k, carry[k], e.c);
          end
          checks++;
          if (err[k] !== e.e) begin
            errors++;
            $display("FAIL err dut=%0d got %b want %b", k, err[k], e.e);
          end
          checks++;
          if (busy[k] !== 1'b0) begin
            errors++;
            $display("FAIL busy_at_done dut=%0d got %b want 0", k, busy[k]);
          end
          checks++;
          if (cyc - e.t != ndig(k) + 1) begin
            errors++;
            $display("FAIL latency dut=%0d got %0d want %0d", k, cyc - e.t - 1, ndig(k));
          end
        end
      end
    end
  end

  task automatic wait_drain();
    for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL done_timeout got pending=%0d want 0", q.size());
      q.delete();
    end
  endtask

  // One single-cycle start; operands are scrambled while the add runs.
  task automatic run_op(input int sel, input logic [31:0] a, input logic [31:0] b, input logic c,
                        input logic [31:0] es, input logic ec, input logic ee);
    @(negedge clk);
    a_w = a;
    b_w = b;
    c0  = c;
    start[sel] = 1'b1;
    q.push_back('{sel: sel, s: es, c: ec, e: ee, t: cyc});
    n_push++;
    @(negedge clk);
    start[sel] = 1'b0;
    checks++;
    if (busy[sel] !== 1'b1) begin
      errors++;
      $display("FAIL busy_high dut=%0d got %b want 1", sel, busy[sel]);
    end
    a_w = $urandom;
    b_w = $urandom;
    c0  = ~c;
    wait_drain();
  endtask

  task automatic run_model_op(input int sel, input logic [31:0] a, input logic [31:0] b, input logic c);
    logic [31:0] es;
    logic        ec, ee;
    model(sel, a, b, c, es, ec, ee);
    run_op(sel, a, b, c, es, ec, ee);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (get_s(k) !== 32'h0 || carry[k] !== 1'b0 || busy[k] !== 1'b0 ||
          done[k] !== 1'b0 || err[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset_state dut=%0d got S=%h C=%b busy=%b done=%b err=%b want all 0",
                 k, get_s(k), carry[k], busy[k], done[k], err[k]);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_directed(input int sel);
    run_model_op(sel, 32'h0000_0033, 32'h0000_0033, 1'b0);
    run_model_op(sel, 32'h0000_0038, 32'h0000_0079, 1'b1);
    run_model_op(sel, 32'h9999_9999, 32'h9999_9999, 1'b1);
    run_model_op(sel, 32'h9999_9999, 32'h0000_0000, 1'b1);
  endtask

  task automatic test_err(input int sel);
    if (ndig(sel) == 1) run_op(sel, 32'h0000_000A, 32'h0000_0001, 1'b0, 32'h1, 1'b1, 1'b1);
    else                run_op(sel, 32'h0000_000A, 32'h0000_0001, 1'b0, 32'h11, 1'b0, 1'b1);
    // A clean add right after must clear the sticky flag.
    run_model_op(sel, 32'h0000_0001, 32'h0000_0002, 1'b0);
  endtask

  task automatic test_random(input int sel);
    for (int i = 0; i < 4; i++)
      run_model_op(sel, rand_bcd(ndig(sel)), rand_bcd(ndig(sel)), 1'($urandom_range(0, 1)));
  endtask

  task automatic test_back_to_back(input int sel);
    logic [31:0] a, b, es;
    logic        c, ec, ee;
    @(negedge clk);
    start[sel] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a = rand_bcd(ndig(sel));
      b = rand_bcd(ndig(sel));
      c = 1'($urandom_range(0, 1));
      model(sel, a, b, c, es, ec, ee);
      a_w = a;
      b_w = b;
      c0  = c;
      q.push_back('{sel: sel, s: es, c: ec, e: ee, t: cyc});
      n_push++;
      for (int j = 0; j < ndig(sel); j++) begin
        @(negedge clk);
        a_w = $urandom;
        b_w = $urandom;
        c0  = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
    end
    start[sel] = 1'b0;
    wait_drain();
  endtask

  task automatic test_reset_abort(input int sel);
    int na;
    na = (ndig(sel) > 2) ? 2 : ndig(sel) - 1;
    @(negedge clk);
    a_w = 32'h0000_0033;
    b_w = 32'h0000_0033;
    c0  = 1'b0;
    start[sel] = 1'b1;
    @(posedge clk);
    #1 start[sel] = 1'b0;
    repeat (na) @(posedge clk);
    #1;
    checks++;
    if (busy[sel] !== 1'b1) begin
      errors++;
      $display("FAIL busy_before_abort dut=%0d got %b want 1", sel, busy[sel]);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (busy[sel] !== 1'b0 || get_s(sel) !== 32'h0 || done[sel] !== 1'b0 || carry[sel] !== 1'b0) begin
      errors++;
      $display("FAIL abort_state dut=%0d got busy=%b S=%h done=%b C=%b want 0 0 0 0",
               sel, busy[sel], get_s(sel), done[sel], carry[sel]);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (ndig(sel) + 2) @(negedge clk);
    run_model_op(sel, 32'h1234_5678, 32'h8765_4329, 1'b1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got no finish want finish before time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    for (int s = 0; s < 3; s++) begin
      test_directed(s);
      test_err(s);
      test_random(s);
      test_back_to_back(s);
      test_reset_abort(s);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (n_done != n_push) begin
      errors++;
      $display("FAIL done_count got %0d want %0d", n_done, n_push);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcdaddn_serial.md
BCDADDN_SERIAL -- requirements
Module: bcdaddn_serial

Interface
REQ-001 The block SHALL have parameter NDIG, default 4, giving the number of BCD digits per operand (legal range 1..16).
REQ-002 The block SHALL have an input port `clk`, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have an input port `rst`, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have an input port `start`, 1 bit: request to add the current A, B and C0.
REQ-005 The block SHALL have an input port `A`, 4*NDIG bits: BCD operand, digit 0 in bits [3:0].
REQ-006 The block SHALL have an input port `B`, 4*NDIG bits: BCD operand, same layout as A.
REQ-007 The block SHALL have an input port `C0`, 1 bit: carry-in to digit 0.
REQ-008 The block SHALL have an output port `S`, 4*NDIG bits: BCD sum, registered.
REQ-009 The block SHALL have an output port `Carry`, 1 bit: carry-out of the most significant digit, registered.
REQ-010 The block SHALL have an output port `busy`, 1 bit: high while an addition is in progress.
REQ-011 The block SHALL have an output port `done`, 1 bit: one-cycle pulse marking S, Carry and err valid.
REQ-012 The block SHALL have an output port `err`, 1 bit: at least one operand digit of the last addition was greater than 9.

Function
REQ-013 The FSM SHALL have two states:
- IDLE (busy=0).
- ADD (busy=1, digit index idx counts 0..NDIG-1).
REQ-014 In IDLE, a clock edge with start=1 SHALL:
- capture A, B and C0 into internal operand registers;
- clear idx, S, Carry and err;
- enter ADD.
REQ-015 start SHALL be ignored while busy=1; later changes on A, B and C0 SHALL NOT affect the addition in progress.
REQ-016 Each clock edge in ADD SHALL process digit idx:
- t = a_idx + b_idx + c, computed 5 bits wide, where c is the running carry;
- if t > 9: S digit idx = (t + 6) mod 16 and c_next = 1;
- otherwise: S digit idx = t and c_next = 0.
REQ-017 err SHALL be set, sticky for the rest of the operation, if a_idx > 9 or b_idx > 9; the correction rule in REQ-016 SHALL still be applied unchanged to those digits.
REQ-018 On the edge that processes digit NDIG-1, the block SHALL:
- load Carry with c_next;
- return to IDLE;
- assert done for exactly the following cycle.
REQ-019 Latency: done SHALL be high NDIG clock edges after the edge that sampled start; busy SHALL drop in the same cycle that done rises.
REQ-020 S, Carry and err SHALL hold their values after done until the next accepted start.
REQ-021 start=1 during the done cycle SHALL be accepted, giving back-to-back operation with one addition every NDIG+1 cycles.
REQ-022 NDIG=1 SHALL work: done follows acceptance after a single ADD edge.

Reset
REQ-023 While rst=1, independent of clk, the block SHALL be in IDLE with the following values:
- S=0, Carry=0, busy=0, done=0, err=0;
- idx=0 and running carry = 0.
REQ-024 rst asserted mid-operation SHALL abort the addition with no done pulse; the first start after rst deasserts SHALL be accepted normally.

Structure
REQ-025 The shared package bcd_pkg SHALL hold the constants BCD_W=4, BCD_MAX=9 and BCD_ADJ=6, and the FSM state encoding (IDLE, ADD).
REQ-026 The per-digit correction in REQ-016 SHALL be one combinational sub-module, bcdadd4, with ports A, B, C0, S and Carry, instantiated once and time-shared across digits by idx.
REQ-027 The operand registers SHALL shift right by one digit per ADD cycle, or be muxed by idx; the selected option SHALL be recorded in the RTL header.

Verification
REQ-028 The bench SHALL cover the following directed scenarios with NDIG=4 (values are BCD shown as hex):
- A=0033, B=0033, C0=0 -> S=0066, Carry=0, err=0, done 4 edges after start.
- A=0038, B=0079, C0=1 -> S=0118, Carry=0; carry ripples across two digits.
- A=9999, B=9999, C0=1 -> S=9999, Carry=1; also A=9999, B=0000, C0=1 -> S=0000, Carry=1 (full wrap).
- A=000A, B=0001, C0=0 -> err=1, S=0011 per the REQ-016 rule.
- start held high through an operation -> exactly one done per NDIG+1 cycles, operands taken at each acceptance edge only.
- rst pulsed 2 cycles after start -> busy=0 and S=0 immediately, no done; next start gives the correct sum.
REQ-029 The bench SHALL repeat these scenarios for NDIG=1 and NDIG=8, checking against a decimal reference model.
